// File: rtl/pooling_scheduler.sv
// pooling_scheduler: sequences 2x2 average-pooling windows from frame RAM through the averaging unit to the output buffer
module pooling_scheduler #(
    parameter int RESOLUTION = 8,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int ADDR_W     = 10,
    parameter int OUT_ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [RESOLUTION-1:0]   rd_data,
    output logic                    avg_go,
    output logic [4*RESOLUTION-1:0] avg_pixels,
    input  logic                    avg_done,
    input  logic [RESOLUTION-1:0]   avg_result,
    output logic                    wr_en,
    output logic [OUT_ADDR_W-1:0]   wr_addr,
    output logic [RESOLUTION-1:0]   wr_data
);
    localparam int NWIN  = (IMG_W / 2) * (IMG_H / 2);
    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_odd_dims
        $error("pooling_scheduler: IMG_W and IMG_H must be even");
    end

    typedef enum logic [2:0] {IDLE, READ, CAPT, LAUNCH, WAIT, WRITE, FIN} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              k;
    logic [1:0]              slot;
    logic [ADDR_W-1:0]       base;
    logic [COL_W-1:0]        col;
    logic [OUT_ADDR_W-1:0]   win;
    logic                    last;
    logic                    col_wrap;
    logic                    accept;

    assign slot     = k - 2'd1;
    assign last     = (win == OUT_ADDR_W'(NWIN - 1));
    assign col_wrap = (col == COL_W'(IMG_W - 2));
    assign accept   = (state == IDLE) && start && !abort;

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state decode and Moore outputs; abort overrides every transition
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE) && (state != FIN);
        done      = (state == FIN);
        rd_en     = (state == READ);
        avg_go    = (state == LAUNCH);
        wr_en     = (state == WRITE);
        wr_addr   = win;
        rd_addr   = rd_en ? base + (k[1] ? ADDR_W'(IMG_W) : '0) + ADDR_W'(k[0]) : '0;
        case (state)
            IDLE:    state_nxt = start ? READ : IDLE;
            READ:    state_nxt = (k == 2'd3) ? CAPT : READ;
            CAPT:    state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    state_nxt = avg_done ? WRITE : WAIT;
            WRITE:   state_nxt = last ? FIN : READ;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // window counters, pixel capture (one cycle behind each read) and result latch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k          <= '0;
            base       <= '0;
            col        <= '0;
            win        <= '0;
            avg_pixels <= '0;
            wr_data    <= '0;
        end else begin
            if (accept) begin
                k    <= '0;
                base <= '0;
                col  <= '0;
                win  <= '0;
            end
            if (state == READ) k <= k + 2'd1;
            if (state == READ && k != 2'd0) avg_pixels[slot*RESOLUTION +: RESOLUTION] <= rd_data;
            if (state == CAPT) avg_pixels[3*RESOLUTION +: RESOLUTION] <= rd_data;
            if (state == WAIT && avg_done) wr_data <= avg_result;
            if (state == WRITE) begin
                win  <= win + 1'b1;
                col  <= col_wrap ? '0 : col + COL_W'(2);
                base <= base + (col_wrap ? ADDR_W'(IMG_W + 2) : ADDR_W'(2));
            end
        end
    end
endmodule

// File: tb/tb_pooling_scheduler.sv
// tb_pooling_scheduler: frame-level checks of the pooling scheduler against a window-arithmetic reference model
module tb_pooling_scheduler;
    localparam int W    = 28;
    localparam int H    = 28;
    localparam int NPIX = W * H;
    localparam int NWIN = (W / 2) * (H / 2);

    typedef struct {
        int lat;
        int spur;
        int ramp;
        int start_win;
        int exp_cyc;
    } run_t;

    typedef struct {
        int win;
        int a0;
        int a1;
        int a2;
        int a3;
    } avec_t;

    logic        clk = 0;
    logic        reset = 1;
    logic        start = 0;
    logic        abort = 0;
    logic        busy, done, rd_en, avg_go, avg_done, wr_en;
    logic [9:0]  rd_addr;
    logic [7:0]  rd_data = '0;
    logic [31:0] avg_pixels;
    logic [7:0]  avg_result;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;

    logic [7:0]  mem [NPIX];
    int          cyc = 0;
    int          avg_lat = 1;
    int          pend = 0;
    int          spur_mode = 0;
    logic [7:0]  res = '0;

    int          errors = 0;
    int          checks = 0;
    logic [9:0]  rd_q [$];
    logic [31:0] go_q [$];
    logic [7:0]  wa_q [$];
    logic [7:0]  wd_q [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          busy_cnt = 0;
    int          unstable = 0;
    logic [31:0] held = '0;
    bit          holding = 0;

    run_t        runs [4];
    avec_t       avec [4];

    pooling_scheduler dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .avg_go(avg_go), .avg_pixels(avg_pixels), .avg_done(avg_done), .avg_result(avg_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] avg4(input logic [31:0] p);
        int s;
        s = int'(p[7:0]) + int'(p[15:8]) + int'(p[23:16]) + int'(p[31:24]);
        return 8'(s / 4);
    endfunction

    function automatic int waddr(input int n, input int j);
        int r, c;
        r = n / (W / 2);
        c = n % (W / 2);
        return (2 * r + j / 2) * W + 2 * c + j % 2;
    endfunction

    function automatic logic [31:0] win_pixels(input int n);
        return {mem[waddr(n, 3)], mem[waddr(n, 2)], mem[waddr(n, 1)], mem[waddr(n, 0)]};
    endfunction

    function automatic logic [63:0] rd_at(input int i);
        return (i < rd_q.size()) ? 64'(rd_q[i]) : 'x;
    endfunction

    function automatic logic [63:0] wa_at(input int i);
        return (i < wa_q.size()) ? 64'(wa_q[i]) : 'x;
    endfunction

    function automatic logic [63:0] wd_at(input int i);
        return (i < wd_q.size()) ? 64'(wd_q[i]) : 'x;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    always @(posedge clk) begin
        if (avg_go) begin
            pend <= avg_lat;
            res  <= avg4(avg_pixels);
        end else if (pend > 0) pend <= pend - 1;
    end

    assign avg_done   = (pend == 1) || (spur_mode != 0 && (rd_en || avg_go));
    assign avg_result = res;

    always @(negedge clk) begin
        if (rd_en) rd_q.push_back(rd_addr);
        if (avg_go) begin
            go_q.push_back(avg_pixels);
            held    = avg_pixels;
            holding = 1;
        end else if (holding) begin
            if (!busy) holding = 0;
            else begin
                if (avg_pixels !== held) unstable++;
                if (wr_en) holding = 0;
            end
        end
        if (wr_en) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (busy) busy_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        rd_q.delete();
        go_q.delete();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
        busy_cnt = 0;
        unstable = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"}, 64'(busy), 0);
        chk({tag, " done"}, 64'(done), 0);
        chk({tag, " rd_en"}, 64'(rd_en), 0);
        chk({tag, " rd_addr"}, 64'(rd_addr), 0);
        chk({tag, " avg_go"}, 64'(avg_go), 0);
        chk({tag, " avg_pixels"}, 64'(avg_pixels), 0);
        chk({tag, " wr_en"}, 64'(wr_en), 0);
        chk({tag, " wr_addr"}, 64'(wr_addr), 0);
        chk({tag, " wr_data"}, 64'(wr_data), 0);
    endtask

    task automatic check_first(input string tag);
        for (int j = 0; j < 4; j++) chk($sformatf("%s rd_addr k%0d", tag, j), rd_at(j), 64'(waddr(0, j)));
        chk({tag, " wr_addr"}, wa_at(0), 0);
        chk({tag, " wr_data"}, wd_at(0), 64'(avg4(win_pixels(0))));
    endtask

    task automatic run_frame(input int idx);
        run_t        r;
        string       tag;
        int          t0;
        bit          pulsed;
        logic [31:0] px;
        r   = runs[idx];
        tag = $sformatf("run%0d", idx);
        for (int i = 0; i < NPIX; i++) mem[i] = (r.ramp != 0) ? 8'(i) : 8'($urandom);
        avg_lat   = r.lat;
        spur_mode = r.spur;
        clear_log();
        start = 1;
        step();
        start = 0;
        t0 = cyc;
        pulsed = 0;
        for (int i = 0; i < r.exp_cyc + 400 && done_cnt == 0; i++) begin
            if (r.start_win >= 0 && !pulsed && wa_q.size() == r.start_win) begin
                start  = 1;
                pulsed = 1;
            end else start = 0;
            step();
        end
        start = 0;
        repeat (20) step();
        spur_mode = 0;
        chk({tag, " done pulses"}, 64'(done_cnt), 1);
        chk({tag, " done latency"}, 64'(done_cyc - t0), 64'(r.exp_cyc));
        chk({tag, " busy cycles"}, 64'(busy_cnt), 64'(r.exp_cyc));
        chk({tag, " busy at end"}, 64'(busy), 0);
        chk({tag, " reads"}, 64'(rd_q.size()), 64'(4 * NWIN));
        chk({tag, " launches"}, 64'(go_q.size()), 64'(NWIN));
        chk({tag, " writes"}, 64'(wa_q.size()), 64'(NWIN));
        chk({tag, " pixels unstable"}, 64'(unstable), 0);
        if (rd_q.size() == 4 * NWIN && go_q.size() == NWIN && wa_q.size() == NWIN) begin
            for (int n = 0; n < NWIN; n++) begin
                px = win_pixels(n);
                for (int j = 0; j < 4; j++)
                    chk($sformatf("%s rd_addr w%0d k%0d", tag, n, j), 64'(rd_q[4 * n + j]), 64'(waddr(n, j)));
                chk($sformatf("%s avg_pixels w%0d", tag, n), 64'(go_q[n]), 64'(px));
                chk($sformatf("%s wr_addr w%0d", tag, n), 64'(wa_q[n]), 64'(n));
                chk($sformatf("%s wr_data w%0d", tag, n), 64'(wd_q[n]), 64'(avg4(px)));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_rd;
        runs[0] = '{1, 0, 1, -1, 1568};
        runs[1] = '{3, 0, 0, -1, 1960};
        runs[2] = '{1, 1, 0, 10, 1568};
        runs[3] = '{2, 1, 0, -1, 1764};
        avec[0] = '{0, 0, 1, 28, 29};
        avec[1] = '{1, 2, 3, 30, 31};
        avec[2] = '{14, 56, 57, 84, 85};
        avec[3] = '{195, 754, 755, 782, 783};

        #1 reset = 0;
        step();
        step();
        check_zero("reset");
        reset = 1;
        step();

        for (int i = 0; i < 4; i++) begin
            run_frame(i);
            if (i == 0 && rd_q.size() == 4 * NWIN) begin
                foreach (avec[v]) begin
                    chk($sformatf("ramp w%0d a0", avec[v].win), 64'(rd_q[4 * avec[v].win]), 64'(avec[v].a0));
                    chk($sformatf("ramp w%0d a1", avec[v].win), 64'(rd_q[4 * avec[v].win + 1]), 64'(avec[v].a1));
                    chk($sformatf("ramp w%0d a2", avec[v].win), 64'(rd_q[4 * avec[v].win + 2]), 64'(avec[v].a2));
                    chk($sformatf("ramp w%0d a3", avec[v].win), 64'(rd_q[4 * avec[v].win + 3]), 64'(avec[v].a3));
                end
            end
        end

        avg_lat = 1;
        clear_log();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 2000 && wa_q.size() < 50; i++) step();
        chk("abort reached window 50", 64'(wa_q.size()), 50);
        abort = 1;
        step();
        abort = 0;
        chk("abort busy", 64'(busy), 0);
        repeat (30) step();
        chk("abort writes", 64'(wa_q.size()), 50);
        chk("abort reads", 64'(rd_q.size()), 200);
        chk("abort launches", 64'(go_q.size()), 50);
        chk("abort done", 64'(done_cnt), 0);

        clear_log();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 50 && wa_q.size() < 1; i++) step();
        check_first("restart after abort");
        abort = 1;
        step();
        abort = 0;
        chk("abort mid-run busy", 64'(busy), 0);
        abort = 1;
        step();
        abort = 0;
        chk("abort in idle busy", 64'(busy), 0);
        n_rd = rd_q.size();
        start = 1;
        abort = 1;
        step();
        start = 0;
        abort = 0;
        step();
        chk("start+abort idle busy", 64'(busy), 0);
        chk("start+abort idle reads", 64'(rd_q.size()), 64'(n_rd));
        start = 1;
        step();
        start = 0;
        chk("start after idle abort busy", 64'(busy), 1);
        abort = 1;
        step();
        abort = 0;

        avg_lat = 3;
        clear_log();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 200 && go_q.size() < 6; i++) step();
        step();
        chk("midwait in wait", 64'(busy), 1);
        reset = 0;
        #1;
        check_zero("midwait reset");
        step();
        step();
        reset = 1;
        step();
        avg_lat = 1;
        clear_log();
        start = 1;
        step();
        start = 0;
        for (int i = 0; i < 50 && wa_q.size() < 1; i++) step();
        check_first("restart after reset");
        abort = 1;
        step();
        abort = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
